// File: rtl/pu_msp430_ram_arb_pkg.sv
// Shared types and constants for the MSP430 RAM arbiter.
// Holds arbiter state, access owner and the RAM read-enable code.
package pu_msp430_pkg;

  typedef enum logic {
    ARB,
    FORCE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    DMA
  } owner_t;

  localparam logic [1:0] RAM_WEN_READ = 2'b11;

endpackage

// File: rtl/pu_msp430_ram_arb_if.sv
// CPU, DMA and RAM bus bundle for the MSP430 RAM arbiter.
// slave: arbiter side; master: requesters plus RAM macro.
interface pu_msp430_ram_arb_if #(
  parameter int ADDR_MSB = 6
);

  logic              cpu_en;
  logic [ADDR_MSB:0] cpu_addr;
  logic [1:0]        cpu_wen;
  logic [15:0]       cpu_din;
  logic [15:0]       cpu_dout;
  logic              cpu_wait;

  logic              dma_req;
  logic [ADDR_MSB:0] dma_addr;
  logic [1:0]        dma_wen;
  logic [15:0]       dma_din;
  logic              dma_gnt;
  logic              dma_resp;
  logic [15:0]       dma_dout;

  logic [ADDR_MSB:0] ram_addr;
  logic              ram_cen;
  logic [1:0]        ram_wen;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;

  modport slave (
    input  cpu_en, cpu_addr, cpu_wen, cpu_din,
    output cpu_dout, cpu_wait,
    input  dma_req, dma_addr, dma_wen, dma_din,
    output dma_gnt, dma_resp, dma_dout,
    output ram_addr, ram_cen, ram_wen, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_en, cpu_addr, cpu_wen, cpu_din,
    input  cpu_dout, cpu_wait,
    output dma_req, dma_addr, dma_wen, dma_din,
    input  dma_gnt, dma_resp, dma_dout,
    input  ram_addr, ram_cen, ram_wen, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/pu_msp430_ram_arb_fair.sv
// DMA starvation guard: wait counter plus ARB/FORCE FSM.
// Ports: mclk, puc_rst_n, cpu_en, dma_req -> dma_gnt, cpu_wait.
module pu_msp430_ram_arb_fair
  import pu_msp430_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic mclk,
  input  logic puc_rst_n,
  input  logic cpu_en,
  input  logic dma_req,
  output logic dma_gnt,
  output logic cpu_wait
);

  localparam int CW = $clog2(DMA_MAX_WAIT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(DMA_MAX_WAIT);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = ARB;
    cnt_d    = '0;
    dma_gnt  = 1'b0;
    cpu_wait = 1'b0;
    unique case (state_q)
      ARB:   dma_gnt = dma_req & ~cpu_en;
      FORCE: begin
        dma_gnt  = dma_req;
        cpu_wait = cpu_en;
      end
      default: ;
    endcase
    if (!puc_rst_n) begin
      dma_gnt  = 1'b0;
      cpu_wait = 1'b0;
    end
    // Refused cycles accumulate; the one that hits the
    // limit books a forced DMA slot for the next cycle.
    if (dma_req && !dma_gnt) begin
      cnt_d = cnt_q + cnt_t'(1);
      if (cnt_d == CNT_MAX)
        state_d = FORCE;
    end
  end

endmodule

// File: rtl/pu_msp430_ram_arb.sv
// CPU/DMA arbiter in front of a single-port MSP430 RAM (mclk, puc_rst_n, bus).
// Macro PU_MSP430_RAM_ARB_DMA_EN enables the DMA port; else CPU only.
module pu_msp430_ram_arb
  import pu_msp430_pkg::*;
#(
  parameter int ADDR_MSB     = 6,
  parameter int MEM_SIZE     = 256,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic mclk,
  input  logic puc_rst_n,
  pu_msp430_ram_arb_if.slave bus
);

  localparam int unsigned MEM_WORDS = MEM_SIZE / 2;

  logic              dma_gnt;
  logic              cpu_wait;
  logic              sel_cpu;
  logic              sel_dma;
  logic              access;
  logic              hit;
  logic [ADDR_MSB:0] sel_addr;
  logic [1:0]        sel_wen;
  logic [15:0]       sel_din;

  owner_t      owner_d, owner_q;
  logic        rd_q;
  logic        hit_q;
  logic [15:0] rd_data;
  logic        cpu_ret;
  logic [15:0] cpu_dout_q;

`ifdef PU_MSP430_RAM_ARB_DMA_EN
  logic        dma_ret;
  logic [15:0] dma_dout_q;

  pu_msp430_ram_arb_fair #(
    .DMA_MAX_WAIT(DMA_MAX_WAIT)
  ) u_fair (
    .mclk     (mclk),
    .puc_rst_n(puc_rst_n),
    .cpu_en   (bus.cpu_en),
    .dma_req  (bus.dma_req),
    .dma_gnt  (dma_gnt),
    .cpu_wait (cpu_wait)
  );

  assign sel_dma  = dma_gnt;
  assign sel_cpu  = bus.cpu_en & ~cpu_wait & ~dma_gnt;
  assign sel_addr = sel_dma ? bus.dma_addr : bus.cpu_addr;
  assign sel_wen  = sel_dma ? bus.dma_wen : bus.cpu_wen;
  assign sel_din  = sel_dma ? bus.dma_din : bus.cpu_din;

  assign dma_ret       = (owner_q == DMA) & rd_q;
  assign bus.dma_resp  = (owner_q == DMA);
  assign bus.dma_dout  = dma_ret ? rd_data : dma_dout_q;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)
      dma_dout_q <= '0;
    else if (dma_ret)
      dma_dout_q <= rd_data;
  end
`else
  assign dma_gnt      = 1'b0;
  assign cpu_wait     = 1'b0;
  assign sel_dma      = 1'b0;
  assign sel_cpu      = bus.cpu_en;
  assign sel_addr     = bus.cpu_addr;
  assign sel_wen      = bus.cpu_wen;
  assign sel_din      = bus.cpu_din;
  assign bus.dma_resp = 1'b0;
  assign bus.dma_dout = '0;
`endif

  assign bus.dma_gnt  = dma_gnt;
  assign bus.cpu_wait = cpu_wait;

  // Out-of-range requests are accepted but never reach the RAM.
  assign access = puc_rst_n & (sel_cpu | sel_dma);
  assign hit    = access & (32'(sel_addr) < MEM_WORDS);

  assign bus.ram_cen  = ~hit;
  assign bus.ram_addr = hit ? sel_addr : '0;
  assign bus.ram_wen  = hit ? sel_wen : RAM_WEN_READ;
  assign bus.ram_din  = hit ? sel_din : '0;

  always_comb begin
    owner_d = NONE;
    unique case (1'b1)
      !access:           owner_d = NONE;
      access && sel_dma: owner_d = DMA;
      access && !sel_dma: owner_d = CPU;
      default:           owner_d = NONE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      owner_q    <= NONE;
      rd_q       <= 1'b0;
      hit_q      <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      owner_q <= owner_d;
      rd_q    <= (sel_wen == RAM_WEN_READ);
      hit_q   <= hit;
      if (cpu_ret)
        cpu_dout_q <= rd_data;
    end
  end

  // Missed accesses read back as zero.
  assign rd_data      = hit_q ? bus.ram_dout : '0;
  assign cpu_ret      = (owner_q == CPU) & rd_q;
  assign bus.cpu_dout = cpu_ret ? rd_data : cpu_dout_q;

endmodule
